// File: rtl/firmware_loader_if.sv
// Firmware loader bus bundle: inbound byte stream plus the write/control
// outputs toward the firmware RAM, vector RAM and CPU reset logic.
// The loader itself is the slave; the stream source / RAM side is the master.
interface firmware_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [13:0] wr_address;
  logic [2:0]  wr_vector;
  logic [7:0]  wr_data;
  logic        wr_firmware;
  logic        wr_vectors;
  logic        cpu_hold;
  logic        done;
  logic        error;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, wr_address, wr_vector, wr_data,
    input  wr_firmware, wr_vectors, cpu_hold, done, error
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, wr_address, wr_vector, wr_data,
    output wr_firmware, wr_vectors, cpu_hold, done, error
  );
endinterface

// File: rtl/firmware_loader.sv
// Firmware loader: parses a byte stream of WRITE (A5) and RUN (5A) packets,
// issues one-cycle write strobes into firmware RAM or the vector RAM, and
// holds the CPU in reset until RUN is received.
// Optional feature macro: FIRMWARE_LOADER_CHECKSUM_EN adds a trailing CHK
// byte per WRITE packet (8-bit sum of ADDR_HI..CHK must be zero).
module firmware_loader #(
  parameter logic [15:0] FW_BASE        = 16'hD000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  firmware_loader_if.slave bus
);

  localparam logic [7:0]  CMD_WRITE    = 8'hA5;
  localparam logic [7:0]  CMD_RUN      = 8'h5A;
  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_HI = 3'd1,
    S_ADDR_LO = 3'd2,
    S_LEN     = 3'd3,
    S_DATA    = 3'd4
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
    ,S_CHK    = 3'd5
`endif
  } state_t;

  state_t      r_state, w_state_next;
  logic [15:0] r_addr, w_addr_next;
  logic [7:0]  r_cnt, w_cnt_next;
  logic [19:0] r_timer, w_timer_next;
  logic        r_wr_fw, w_wr_fw_next;
  logic        r_wr_vec, w_wr_vec_next;
  logic [13:0] r_wr_address, w_wr_address_next;
  logic [2:0]  r_wr_vector, w_wr_vector_next;
  logic [7:0]  r_wr_data, w_wr_data_next;
  logic        r_cpu_hold, w_cpu_hold_next;
  logic        r_done, w_done_next;
  logic        r_error, w_error_next;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
  logic [7:0]  r_sum, w_sum_next;
  logic [7:0]  w_chk_total;
`endif

  logic        w_strobe_fw, w_strobe_vec, w_rx_ready, w_accept;
  logic        w_in_fw, w_in_vec, w_last, w_at_top, w_timeout;
  logic [13:0] w_fw_offset;
  logic [2:0]  w_vec_index;

  // Strobes are masked while rst is high so a pending write never escapes;
  // the loader stalls the stream for exactly the cycle a strobe is out.
  assign w_strobe_fw  = r_wr_fw & ~rst;
  assign w_strobe_vec = r_wr_vec & ~rst;
  assign w_rx_ready   = ~(w_strobe_fw | w_strobe_vec);
  assign w_accept     = bus.rx_valid & w_rx_ready;

  // Current target address decode; r_addr always holds the next byte's target.
  assign w_in_fw     = (r_addr >= FW_BASE) && (r_addr <= 16'hFFF9);
  assign w_in_vec    = (r_addr >= 16'hFFFA);
  assign w_fw_offset = r_addr[13:0] - FW_BASE[13:0];
  assign w_vec_index = r_addr[2:0] - 3'd2;
  assign w_last      = (r_cnt == 8'd0);
  assign w_at_top    = (r_addr == 16'hFFFF);
  assign w_timeout   = (r_state != S_IDLE) && !w_accept && (r_timer == TIMEOUT_LAST);
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
  assign w_chk_total = r_sum + bus.rx_data;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: advance on each accepted byte, bail to IDLE on timeout
  // or when the address would wrap past the top of memory.
  always_comb begin
    w_state_next = r_state;
    if (w_timeout) begin
      w_state_next = S_IDLE;
    end else if (w_accept) begin
      case (r_state)
        S_IDLE:    if (bus.rx_data == CMD_WRITE) w_state_next = S_ADDR_HI;
        S_ADDR_HI: w_state_next = S_ADDR_LO;
        S_ADDR_LO: w_state_next = S_LEN;
        S_LEN:     w_state_next = S_DATA;
        S_DATA: begin
          if (w_last) begin
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
            w_state_next = S_CHK;
`else
            w_state_next = S_IDLE;
`endif
          end else if (w_at_top) begin
            w_state_next = S_IDLE;
          end
        end
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
        S_CHK:     w_state_next = S_IDLE;
`endif
        default:   w_state_next = S_IDLE;
      endcase
    end
  end

  // Output/datapath logic: next values of address, count, strobes and flags.
  always_comb begin
    w_addr_next       = r_addr;
    w_cnt_next        = r_cnt;
    w_wr_fw_next      = 1'b0;
    w_wr_vec_next     = 1'b0;
    w_wr_address_next = r_wr_address;
    w_wr_vector_next  = r_wr_vector;
    w_wr_data_next    = r_wr_data;
    w_cpu_hold_next   = r_cpu_hold;
    w_done_next       = 1'b0;
    w_error_next      = r_error;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
    w_sum_next        = r_sum;
`endif
    if (w_accept || (r_state == S_IDLE) || w_timeout) w_timer_next = 20'd0;
    else                                               w_timer_next = r_timer + 20'd1;

    if (w_timeout) begin
      w_error_next = 1'b1;
    end else if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          if (bus.rx_data == CMD_WRITE) begin
            w_error_next    = 1'b0;
            w_cpu_hold_next = 1'b1;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
            w_sum_next      = 8'd0;
`endif
          end else if (bus.rx_data == CMD_RUN) begin
            w_cpu_hold_next = 1'b0;
            w_done_next     = 1'b1;
          end
        end
        S_ADDR_HI: begin
          w_addr_next[15:8] = bus.rx_data;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
          w_sum_next        = r_sum + bus.rx_data;
`endif
        end
        S_ADDR_LO: begin
          w_addr_next[7:0] = bus.rx_data;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
          w_sum_next       = r_sum + bus.rx_data;
`endif
        end
        S_LEN: begin
          w_cnt_next = bus.rx_data;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
          w_sum_next = r_sum + bus.rx_data;
`endif
        end
        S_DATA: begin
          w_addr_next = r_addr + 16'd1;
          w_cnt_next  = r_cnt - 8'd1;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
          w_sum_next  = r_sum + bus.rx_data;
`endif
          if (w_in_fw) begin
            w_wr_fw_next      = 1'b1;
            w_wr_address_next = w_fw_offset;
            w_wr_data_next    = bus.rx_data;
          end else if (w_in_vec) begin
            w_wr_vec_next    = 1'b1;
            w_wr_vector_next = w_vec_index;
            w_wr_data_next   = bus.rx_data;
          end else begin
            w_error_next = 1'b1;
          end
          // More bytes remain but the address space is exhausted.
          if (!w_last && w_at_top) w_error_next = 1'b1;
        end
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_chk_total != 8'd0) w_error_next = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= 16'd0;
      r_cnt        <= 8'd0;
      r_timer      <= 20'd0;
      r_wr_fw      <= 1'b0;
      r_wr_vec     <= 1'b0;
      r_wr_address <= 14'd0;
      r_wr_vector  <= 3'd0;
      r_wr_data    <= 8'd0;
      r_cpu_hold   <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
      r_sum        <= 8'd0;
`endif
    end else begin
      r_addr       <= w_addr_next;
      r_cnt        <= w_cnt_next;
      r_timer      <= w_timer_next;
      r_wr_fw      <= w_wr_fw_next;
      r_wr_vec     <= w_wr_vec_next;
      r_wr_address <= w_wr_address_next;
      r_wr_vector  <= w_wr_vector_next;
      r_wr_data    <= w_wr_data_next;
      r_cpu_hold   <= w_cpu_hold_next;
      r_done       <= w_done_next;
      r_error      <= w_error_next;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
      r_sum        <= w_sum_next;
`endif
    end
  end

  assign bus.rx_ready    = w_rx_ready;
  assign bus.wr_firmware = w_strobe_fw;
  assign bus.wr_vectors  = w_strobe_vec;
  assign bus.wr_address  = r_wr_address;
  assign bus.wr_vector   = r_wr_vector;
  assign bus.wr_data     = r_wr_data;
  assign bus.cpu_hold    = r_cpu_hold;
  assign bus.done        = r_done;
  assign bus.error       = r_error;

endmodule
